// File: rtl/mdio_master_subsystem_if.sv
// Host-side request/response bundle of the MDIO management subsystem.
// The host drives requests through 'master'; the subsystem answers through 'slave'.
interface mdio_master_subsystem_if;
   logic        start;
   logic        write_en;
   logic [4:0]  phy_addr;
   logic [4:0]  reg_addr;
   logic [15:0] data_in;
   logic        busy;
   logic        data_out_valid;
   logic [15:0] data_out;

   modport master (output start, write_en, phy_addr, reg_addr, data_in,
                   input  busy, data_out_valid, data_out);
   modport slave  (input  start, write_en, phy_addr, reg_addr, data_in,
                   output busy, data_out_valid, data_out);
endinterface

// File: rtl/mdio_master_subsystem.sv
// Clause-22 MDIO master plus two on-chip register slaves (GMII-to-RGMII bridge model
// and a user bank) sharing one internal MDC/MDIO line with a pull-up.
module mdio_reg_port #(
   parameter logic [4:0] PHY_ADDR = 5'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mdc_rise,
   input  logic        mdc_fall,
   input  logic        mdio,
   input  logic [15:0] rd_data,
   output logic        oe,
   output logic        dout,
   output logic        wr_stb,
   output logic [4:0]  reg_addr,
   output logic [15:0] wr_data
);
   typedef enum logic [2:0] {S_HUNT, S_ST, S_HDR, S_TA, S_DATA} s_state_e;

   s_state_e    state_q, state_d;
   logic [5:0]  ones_q, ones_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [11:0] hdr_q, hdr_d;
   logic [15:0] wd_q, wd_d, sh_q, sh_d;
   logic        oe_q, oe_d, dout_q, dout_d;
   logic        match, is_rd, is_wr;

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_HUNT;
         ones_q  <= '0;
         cnt_q   <= '0;
         hdr_q   <= '0;
         wd_q    <= '0;
         sh_q    <= '0;
         oe_q    <= 1'b0;
         dout_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ones_q  <= ones_d;
         cnt_q   <= cnt_d;
         hdr_q   <= hdr_d;
         wd_q    <= wd_d;
         sh_q    <= sh_d;
         oe_q    <= oe_d;
         dout_q  <= dout_d;
      end
   end

   // hdr_q = {OP[1:0], PHYAD[4:0], REGAD[4:0]} once the header has been shifted in.
   assign match    = (hdr_q[9:5] == PHY_ADDR);
   assign is_rd    = (hdr_q[11:10] == 2'b10);
   assign is_wr    = (hdr_q[11:10] == 2'b01);
   assign reg_addr = hdr_q[4:0];
   assign wr_data  = {wd_q[14:0], mdio};
   assign oe       = oe_q;
   assign dout     = dout_q;

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      state_d = state_q;
      ones_d  = ones_q;
      cnt_d   = cnt_q;
      hdr_d   = hdr_q;
      wd_d    = wd_q;
      sh_d    = sh_q;
      oe_d    = oe_q;
      dout_d  = dout_q;
      wr_stb  = 1'b0;
      if (mdc_rise) begin
         unique case (state_q)
            S_HUNT: begin
               if (mdio) begin
                  ones_d = (ones_q == 6'd32) ? ones_q : ones_q + 6'd1;
               end else begin
                  ones_d = '0;
                  if (ones_q == 6'd32) state_d = S_ST;
               end
            end
            S_ST: begin
               state_d = mdio ? S_HDR : S_HUNT;
               cnt_d   = '0;
            end
            S_HDR: begin
               hdr_d = {hdr_q[10:0], mdio};
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd11) begin
                  state_d = S_TA;
                  cnt_d   = '0;
               end
            end
            S_TA: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               wd_d  = wr_data;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_d = S_HUNT;
                  cnt_d   = '0;
                  wr_stb  = match && is_wr;
               end
            end
            default: state_d = S_HUNT;
         endcase
      end
      if (mdc_fall) begin
         unique case (state_q)
            S_TA: begin
               // Falling edge that ends TA bit 1: take the line and drive the TA zero.
               if (cnt_q == 4'd1 && match && is_rd) begin
                  oe_d   = 1'b1;
                  dout_d = 1'b0;
                  sh_d   = rd_data;
               end
            end
            S_DATA: begin
               dout_d = sh_q[15];
               sh_d   = {sh_q[14:0], 1'b0};
            end
            default: begin
               oe_d   = 1'b0;
               dout_d = 1'b1;
            end
         endcase
      end
   end
endmodule

module mdio_master_subsystem #(
   parameter logic [4:0]  CORE_PHY_ADDR = 5'h08,
   parameter logic [4:0]  USER_PHY_ADDR = 5'h01,
   parameter int          CLK_DIV       = 1,
   parameter logic [15:0] USER_ID       = 16'hCAFE
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mdio_master_subsystem_if.slave host,
   output logic                   mdc,
   output logic                   mdio,
   output logic [1:0]             speed_mode
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic {M_IDLE, M_FRAME} m_state_e;

   m_state_e         state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [6:0]       hp_cnt_q, hp_cnt_d;
   logic             mdc_q, mdc_d, wr_q, wr_d, valid_q, valid_d;
   logic [63:0]      frame_q, frame_d;
   logic [15:0]      rd_shift_q, rd_shift_d, data_out_q, data_out_d;
   logic             tick, mdc_rise, mdc_fall, m_oe;
   logic [15:0]      ctrl_q, ctrl_d;
   logic [15:0]      user_q [1:3];
   logic [15:0]      user_d [1:3];
   logic             b_oe, b_out, b_wr, u_oe, u_out, u_wr;
   logic [4:0]       b_reg, u_reg;
   logic [15:0]      b_wdata, u_wdata, b_rdata, u_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= M_IDLE;
         div_cnt_q  <= '0;
         hp_cnt_q   <= '0;
         mdc_q      <= 1'b0;
         wr_q       <= 1'b0;
         valid_q    <= 1'b0;
         frame_q    <= '1;
         rd_shift_q <= '0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         hp_cnt_q   <= hp_cnt_d;
         mdc_q      <= mdc_d;
         wr_q       <= wr_d;
         valid_q    <= valid_d;
         frame_q    <= frame_d;
         rd_shift_q <= rd_shift_d;
         data_out_q <= data_out_d;
      end
   end

   assign tick = (div_cnt_q == DIV_W'(CLK_DIV - 1));

   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      hp_cnt_d   = hp_cnt_q;
      mdc_d      = mdc_q;
      wr_d       = wr_q;
      valid_d    = 1'b0;
      frame_d    = frame_q;
      rd_shift_d = rd_shift_q;
      data_out_d = data_out_q;
      mdc_rise   = 1'b0;
      mdc_fall   = 1'b0;
      unique case (state_q)
         M_IDLE: begin
            if (host.start) begin
               state_d   = M_FRAME;
               wr_d      = host.write_en;
               div_cnt_d = '0;
               hp_cnt_d  = '0;
               mdc_d     = 1'b0;
               frame_d   = {32'hFFFF_FFFF, 2'b01,
                            host.write_en ? 2'b01 : 2'b10,
                            host.phy_addr, host.reg_addr,
                            host.write_en ? 2'b10 : 2'b11,
                            host.write_en ? host.data_in : 16'hFFFF};
            end
         end
         M_FRAME: begin
            if (tick) begin
               div_cnt_d = '0;
               mdc_d     = ~mdc_q;
               hp_cnt_d  = hp_cnt_q + 7'd1;
               if (mdc_q) begin
                  mdc_fall = 1'b1;
                  frame_d  = {frame_q[62:0], 1'b1};
               end else begin
                  mdc_rise   = 1'b1;
                  rd_shift_d = {rd_shift_q[14:0], mdio};
               end
               // The last falling edge closes the frame; the final 16 samples are the read data.
               if (hp_cnt_q == 7'd127) begin
                  state_d = M_IDLE;
                  valid_d = ~wr_q;
                  if (!wr_q) data_out_d = rd_shift_q;
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         default: state_d = M_IDLE;
      endcase
   end

   // The master releases the line from the first TA bit (half-period 92) on reads.
   assign m_oe = (state_q == M_FRAME) && (wr_q || (hp_cnt_q < 7'd92));

   always_comb begin
      if (m_oe)      mdio = frame_q[63];
      else if (b_oe) mdio = b_out;
      else if (u_oe) mdio = u_out;
      else           mdio = 1'b1;
   end

   mdio_reg_port #(.PHY_ADDR(CORE_PHY_ADDR)) u_bridge_port (
      .clk(clk), .rst_n(rst_n), .mdc_rise(mdc_rise), .mdc_fall(mdc_fall), .mdio(mdio),
      .rd_data(b_rdata), .oe(b_oe), .dout(b_out), .wr_stb(b_wr), .reg_addr(b_reg),
      .wr_data(b_wdata)
   );

   mdio_reg_port #(.PHY_ADDR(USER_PHY_ADDR)) u_user_port (
      .clk(clk), .rst_n(rst_n), .mdc_rise(mdc_rise), .mdc_fall(mdc_fall), .mdio(mdio),
      .rd_data(u_rdata), .oe(u_oe), .dout(u_out), .wr_stb(u_wr), .reg_addr(u_reg),
      .wr_data(u_wdata)
   );

   // NOTE: these few registers have defined reset values, so they are plain reset flops, not a RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= '0;
         for (int i = 1; i <= 3; i++) user_q[i] <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         for (int i = 1; i <= 3; i++) user_q[i] <= user_d[i];
      end
   end

   always_comb begin
      ctrl_d = ctrl_q;
      user_d = user_q;
      if (b_wr && b_reg == 5'h10) ctrl_d = b_wdata;
      if (u_wr) begin
         case (u_reg)
            5'h01:   user_d[1] = u_wdata;
            5'h02:   user_d[2] = u_wdata;
            5'h03:   user_d[3] = u_wdata;
            default: ;
         endcase
      end
   end

   assign speed_mode = {ctrl_q[6], ctrl_q[13]};

   always_comb begin
      case (b_reg)
         5'h10:   b_rdata = ctrl_q;
         5'h11:   b_rdata = {12'h000, 1'b1, speed_mode, 1'b1};
         default: b_rdata = '0;
      endcase
      case (u_reg)
         5'h00:   u_rdata = USER_ID;
         5'h01:   u_rdata = user_q[1];
         5'h02:   u_rdata = user_q[2];
         5'h03:   u_rdata = user_q[3];
         default: u_rdata = '0;
      endcase
   end

   assign host.busy           = (state_q == M_FRAME);
   assign host.data_out_valid = valid_q;
   assign host.data_out       = data_out_q;
   assign mdc                 = mdc_q;
endmodule

// File: tb/tb_mdio_master_subsystem.sv
// Randomized bench for mdio_master_subsystem: every frame is rebuilt from the sampled
// MDC/MDIO line and compared, with read data, against a register-map model.
module tb_mdio_master_subsystem;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       mdc, mdio;
   logic [1:0] speed_mode;

   mdio_master_subsystem_if bus ();

   mdio_master_subsystem dut (
      .clk(clk), .rst_n(rst_n), .host(bus.slave),
      .mdc(mdc), .mdio(mdio), .speed_mode(speed_mode)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] ctrl_m;
   logic [15:0] user_m [1:3];
   logic [15:0] last_rd;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] model_read(input logic [4:0] phy, input logic [4:0] rg);
      if (phy == 5'h08) begin
         if (rg == 5'h10) return ctrl_m;
         if (rg == 5'h11) return {12'h000, 1'b1, ctrl_m[6], ctrl_m[13], 1'b1};
         return 16'h0000;
      end
      if (phy == 5'h01) begin
         if (rg == 5'h00) return 16'hCAFE;
         if (rg >= 5'h01 && rg <= 5'h03) return user_m[int'(rg)];
         return 16'h0000;
      end
      return 16'hFFFF;
   endfunction

   task automatic model_write(input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] d);
      if (phy == 5'h08 && rg == 5'h10) ctrl_m = d;
      if (phy == 5'h01 && rg >= 5'h01 && rg <= 5'h03) user_m[int'(rg)] = d;
   endtask

   task automatic model_reset();
      ctrl_m  = '0;
      for (int i = 1; i <= 3; i++) user_m[i] = '0;
      last_rd = '0;
   endtask

   task automatic issue(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                        input logic [15:0] d);
      @(posedge clk); #1;
      bus.start    = 1'b1;
      bus.write_en = wr;
      bus.phy_addr = phy;
      bus.reg_addr = rg;
      bus.data_in  = d;
   endtask

   // Follows one frame from busy rising to one cycle after it falls.
   task automatic observe(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                          input logic [15:0] d, input bit toggle, input bit drop);
      int          w = 0, cyc = 0, nb = 0, viol = 0;
      logic [63:0] bits = '0;
      logic        prev = 1'b0;
      logic [15:0] exp_d;
      logic [1:0]  ta;
      bit          matched;
      while (!bus.busy && w < 16) begin
         @(posedge clk); #1;
         w++;
      end
      if (!bus.busy) begin
         check("busy_rise", bus.busy, 1'b1);
         bus.start = 1'b0;
         return;
      end
      if (drop) bus.start = 1'b0;
      while (bus.busy && cyc < 1000) begin
         if (mdc && !prev) begin
            bits = {bits[62:0], mdio};
            nb++;
         end
         prev = mdc;
         if (bus.data_out_valid) viol++;
         if (toggle) begin
            if (cyc >= 4 && cyc < 100) begin
               bus.start    = 1'($urandom_range(0, 1));
               bus.write_en = 1'($urandom_range(0, 1));
               bus.phy_addr = 5'($urandom);
               bus.data_in  = 16'($urandom);
            end else if (cyc == 100) begin
               bus.start = 1'b0;
            end
         end
         cyc++;
         @(posedge clk); #1;
      end
      matched = (phy == 5'h08) || (phy == 5'h01);
      exp_d   = wr ? d : model_read(phy, rg);
      ta      = (wr || matched) ? 2'b10 : 2'b11;
      check("busy_len", 64'(cyc), 64'd128);
      check("mdc_rises", 64'(nb), 64'd64);
      check("valid_during_busy", 64'(viol), 64'd0);
      check("valid_at_end", bus.data_out_valid, !wr);
      check("frame_bits", bits, {32'hFFFF_FFFF, 2'b01, wr ? 2'b01 : 2'b10, phy, rg, ta, exp_d});
      if (wr) begin
         check("data_out_hold", bus.data_out, last_rd);
         model_write(phy, rg, d);
      end else begin
         check("read_data", bus.data_out, exp_d);
         last_rd = exp_d;
      end
      check("speed_mode", speed_mode, {ctrl_m[6], ctrl_m[13]});
      @(posedge clk); #1;
      check("valid_one_cycle", bus.data_out_valid, 1'b0);
      check("mdc_low_after", mdc, 1'b0);
      check("mdio_high_after", mdio, 1'b1);
   endtask

   task automatic txn(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                      input logic [15:0] d);
      issue(wr, phy, rg, d);
      observe(wr, phy, rg, d, 1'b0, 1'b1);
   endtask

   initial begin
      logic [4:0]  phy, rg;
      logic [4:0]  regs [6];
      logic [15:0] d;
      logic        wr;
      regs = '{5'h10, 5'h11, 5'h00, 5'h01, 5'h02, 5'h03};

      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.write_en = 1'b0;
      bus.phy_addr = '0;
      bus.reg_addr = '0;
      bus.data_in  = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", bus.busy, 1'b0);
      check("rst_valid", bus.data_out_valid, 1'b0);
      check("rst_data_out", bus.data_out, 16'h0000);
      check("rst_mdc", mdc, 1'b0);
      check("rst_mdio", mdio, 1'b1);
      check("rst_speed_mode", speed_mode, 2'b00);
      rst_n = 1'b1;

      txn(1'b1, 5'h08, 5'h10, 16'h0140);
      check("speed_mode_0140", speed_mode, 2'b10);
      txn(1'b0, 5'h08, 5'h10, 16'h0);
      txn(1'b0, 5'h08, 5'h11, 16'h0);
      check("bridge_status", bus.data_out, 16'h000D);
      txn(1'b0, 5'h08, 5'h12, 16'h0);
      txn(1'b1, 5'h01, 5'h01, 16'hAAAA);
      txn(1'b0, 5'h01, 5'h01, 16'h0);
      txn(1'b0, 5'h01, 5'h00, 16'h0);
      check("user_id", bus.data_out, 16'hCAFE);
      txn(1'b0, 5'h08, 5'h10, 16'h0);
      txn(1'b0, 5'h05, 5'h00, 16'h0);
      check("unmatched_ffff", bus.data_out, 16'hFFFF);

      // start toggled while busy must not disturb the frame
      issue(1'b0, 5'h08, 5'h11, 16'h0);
      observe(1'b0, 5'h08, 5'h11, 16'h0, 1'b1, 1'b1);

      // start held high: back-to-back frames
      issue(1'b0, 5'h01, 5'h00, 16'h0);
      observe(1'b0, 5'h01, 5'h00, 16'h0, 1'b0, 1'b0);
      observe(1'b0, 5'h01, 5'h00, 16'h0, 1'b0, 1'b0);
      observe(1'b0, 5'h01, 5'h00, 16'h0, 1'b0, 1'b1);

      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 3))
            0:       phy = 5'h08;
            1:       phy = 5'h01;
            default: phy = 5'($urandom);
         endcase
         rg = ($urandom_range(0, 1) == 0) ? regs[$urandom_range(0, 5)] : 5'($urandom);
         d  = 16'($urandom);
         wr = 1'($urandom_range(0, 1));
         txn(wr, phy, rg, d);
      end

      // reset in the middle of a write aborts the frame and discards the data
      issue(1'b1, 5'h01, 5'h02, 16'h1234);
      repeat (60) @(posedge clk);
      #3;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      #1;
      check("abort_busy", bus.busy, 1'b0);
      check("abort_valid", bus.data_out_valid, 1'b0);
      check("abort_mdc", mdc, 1'b0);
      check("abort_mdio", mdio, 1'b1);
      check("abort_data_out", bus.data_out, 16'h0000);
      check("abort_speed_mode", speed_mode, 2'b00);
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      txn(1'b0, 5'h01, 5'h02, 16'h0);
      check("user2_after_abort", bus.data_out, 16'h0000);
      txn(1'b0, 5'h08, 5'h10, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
